digit_entry_reg: RTL and testbench

//  Parametrised keypad credential collector: captures ID_DIGITS+PW_DIGITS digits, one per Submit,
//  MSB-first into a packed word, then presents it on a valid/ready handshake to the authentication FSM.

---
 rtl/digit_entry_pkg.sv | 26 ++
 rtl/entry_timeout_timer.sv | 58 +++++
 rtl/digit_entry_reg.sv | 153 +++++++++++++++
 tb/tb_digit_entry_reg.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/digit_entry_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : digit_entry_pkg                                                 |
// | Purpose  : Shared types and helpers for the keypad credential collector.   |
// |            - state_e   : collector FSM states                              |
// |            - BCD_MAX   : largest digit accepted when BCD checking is on     |
// |            - total_w() : width of the packed credential word               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package digit_entry_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,   // no digits held
    ENTRY   = 2'd1,   // some, but not all, digits held
    ARMED   = 2'd2,   // all digits held, waiting for the commit Submit
    PRESENT = 2'd3    // word offered to the consumer
  } state_e;

  localparam int unsigned BCD_MAX = 9;

  function automatic int total_w(input int digits, input int digit_w);
    return digits * digit_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/entry_timeout_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : entry_timeout_timer                                             |
// | Purpose  : Inactivity timer for a partial keypad entry. Counts cycles while |
// |            run=1 and restart=0; flags expired on the idle cycle that would  |
// |            reach TIMEOUT_CYC. TIMEOUT_CYC=0 disables the timer entirely.    |
// | Ports    : Clk     in  clock, rising edge                                   |
// |            Reset   in  asynchronous active-high reset                       |
// |            run     in  1 while a partial entry is held                      |
// |            restart in  activity this cycle; counter returns to 0            |
// |            expired out combinational: idle limit reached this cycle         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module entry_timeout_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic run,
  input  logic restart,
  output logic expired
);

  generate
    if (TIMEOUT_CYC > 0) begin : g_timer
      localparam int            TW     = $clog2(TIMEOUT_CYC + 1);
      localparam logic [TW-1:0] c_last = TW'(TIMEOUT_CYC - 1);

      logic [TW-1:0] cnt_q;
      logic [TW-1:0] cnt_d;
      logic          hit;

      // cnt_q holds the number of idle cycles already seen; the cycle on
      // which it equals TIMEOUT_CYC-1 and is idle again is the limit.
      always_comb begin
        hit   = run && !restart && (cnt_q == c_last);
        cnt_d = cnt_q + TW'(1);
        if (!run || restart || hit) begin
          cnt_d = '0;
        end
      end

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expired = hit;
    end else begin : g_no_timer
      assign expired = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/digit_entry_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : digit_entry_reg                                                 |
// | Purpose  : Collects ID_DIGITS+PW_DIGITS keypad digits, MSB-first, into a   |
// |            packed word and offers it on a valid/ready handshake. Supports  |
// |            Backspace, Clear, optional BCD check and inactivity timeout.     |
// | Ports    : Clk, Reset (async, active-high)                                 |
// |            Submit/Backspace/Clear  one-cycle strobes                        |
// |            DataIn      digit sampled with Submit                            |
// |            Ready       consumer accepts DataOut while ValidData=1           |
// |            DataOut     committed word, digit 0 in the top DIGIT_W bits      |
// |            ValidData   DataOut valid, held until Ready                      |
// |            DigitCount  digits currently held                                |
// |            InIdField   1 while still collecting ID digits                   |
// |            DigitError  pulse: Submit rejected by BCD check                  |
// |            Timeout     pulse: partial entry discarded for inactivity        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module digit_entry_reg
  import digit_entry_pkg::*;
#(
  parameter  int DIGIT_W     = 4,
  parameter  int ID_DIGITS   = 4,
  parameter  int PW_DIGITS   = 4,
  parameter  bit BCD_ONLY    = 1'b1,
  parameter  int TIMEOUT_CYC = 1000,
  localparam int N           = ID_DIGITS + PW_DIGITS,
  localparam int TOTAL_W     = total_w(N, DIGIT_W),
  localparam int CNT_W       = $clog2(N + 1)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Submit,
  input  logic               Backspace,
  input  logic               Clear,
  input  logic [DIGIT_W-1:0] DataIn,
  input  logic               Ready,
  output logic [TOTAL_W-1:0] DataOut,
  output logic               ValidData,
  output logic [CNT_W-1:0]   DigitCount,
  output logic               InIdField,
  output logic               DigitError,
  output logic               Timeout
);

  state_e             state_q, state_d;
  logic [TOTAL_W-1:0] buf_q,   buf_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TOTAL_W-1:0] dout_q,  dout_d;
  logic               valid_q, valid_d;
  logic               derr_q,  derr_d;
  logic               tout_q,  tout_d;

  logic               timer_run;
  logic               timer_restart;
  logic               timer_expired;
  logic               digit_bad;

  // Only a held, uncommitted entry can time out. Clear is folded into the
  // restart so that any strobe wins over an expiry on the same cycle.
  assign timer_run     = (state_q == ENTRY) || (state_q == ARMED);
  assign timer_restart = Submit || Backspace || Clear;

  entry_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .run     (timer_run),
    .restart (timer_restart),
    .expired (timer_expired)
  );

  assign digit_bad = BCD_ONLY && (32'(DataIn) > BCD_MAX);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    count_d = count_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    derr_d  = 1'b0;
    tout_d  = 1'b0;

    if (state_q == PRESENT) begin
      // Entry strobes are locked out until the consumer takes the word.
      if (Ready) begin
        valid_d = 1'b0;
        buf_d   = '0;
        count_d = '0;
        state_d = IDLE;
      end
    end else if (Clear) begin
      buf_d   = '0;
      count_d = '0;
      state_d = IDLE;
    end else if (Backspace) begin
      if (count_q != '0) begin
        // Slot count-1 sits (N-count) digits above bit 0.
        buf_d[(N - int'(count_q)) * DIGIT_W +: DIGIT_W] = '0;
        count_d = count_q - CNT_W'(1);
        state_d = (count_q == CNT_W'(1)) ? IDLE : ENTRY;
      end
    end else if (Submit) begin
      if (state_q == ARMED) begin
        dout_d  = buf_q;
        valid_d = 1'b1;
        state_d = PRESENT;
      end else if (digit_bad) begin
        derr_d = 1'b1;
      end else begin
        // Slot count sits (N-1-count) digits above bit 0.
        buf_d[(N - 1 - int'(count_q)) * DIGIT_W +: DIGIT_W] = DataIn;
        count_d = count_q + CNT_W'(1);
        state_d = (count_q == CNT_W'(N - 1)) ? ARMED : ENTRY;
      end
    end else if (timer_expired) begin
      buf_d   = '0;
      count_d = '0;
      tout_d  = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      derr_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      derr_q  <= derr_d;
      tout_q  <= tout_d;
    end
  end

  assign DataOut    = dout_q;
  assign ValidData  = valid_q;
  assign DigitCount = count_q;
  assign InIdField  = (count_q < CNT_W'(ID_DIGITS));
  assign DigitError = derr_q;
  assign Timeout    = tout_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_entry_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_digit_entry_reg                                              |
// | Purpose  : Directed self-checking bench. Three collectors share one        |
// |            stimulus stream: u_dut_a (defaults), u_dut_b (BCD_ONLY=0) and    |
// |            u_dut_c (TIMEOUT_CYC=10), so parameter-dependent behaviour is    |
// |            compared side by side.                                           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_digit_entry_reg;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Submit;
  logic       Backspace;
  logic       Clear;
  logic       Ready;
  logic [3:0] DataIn;

  logic [31:0] dout_a, dout_b, dout_c;
  logic        valid_a, valid_b, valid_c;
  logic [3:0]  cnt_a, cnt_b, cnt_c;
  logic        id_a, id_b, id_c;
  logic        derr_a, derr_b, derr_c;
  logic        to_a, to_b, to_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  digit_entry_reg u_dut_a (
    .Clk(Clk), .Reset(Reset), .Submit(Submit), .Backspace(Backspace),
    .Clear(Clear), .DataIn(DataIn), .Ready(Ready), .DataOut(dout_a),
    .ValidData(valid_a), .DigitCount(cnt_a), .InIdField(id_a),
    .DigitError(derr_a), .Timeout(to_a)
  );

  digit_entry_reg #(.BCD_ONLY(1'b0)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .Submit(Submit), .Backspace(Backspace),
    .Clear(Clear), .DataIn(DataIn), .Ready(Ready), .DataOut(dout_b),
    .ValidData(valid_b), .DigitCount(cnt_b), .InIdField(id_b),
    .DigitError(derr_b), .Timeout(to_b)
  );

  digit_entry_reg #(.TIMEOUT_CYC(10)) u_dut_c (
    .Clk(Clk), .Reset(Reset), .Submit(Submit), .Backspace(Backspace),
    .Clear(Clear), .DataIn(DataIn), .Ready(Ready), .DataOut(dout_c),
    .ValidData(valid_c), .DigitCount(cnt_c), .InIdField(id_c),
    .DigitError(derr_c), .Timeout(to_c)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // All strobe tasks start and end on a falling edge.
  task automatic submit(input logic [3:0] d);
    Submit = 1'b1;
    DataIn = d;
    @(negedge Clk);
    Submit = 1'b0;
    DataIn = 4'h0;
  endtask

  task automatic backspace();
    Backspace = 1'b1;
    @(negedge Clk);
    Backspace = 1'b0;
  endtask

  task automatic clear();
    Clear = 1'b1;
    @(negedge Clk);
    Clear = 1'b0;
  endtask

  task automatic ready_pulse();
    Ready = 1'b1;
    @(negedge Clk);
    Ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    logic [31:0] digits;

    Reset = 1'b1; Submit = 1'b0; Backspace = 1'b0; Clear = 1'b0;
    Ready = 1'b0; DataIn = 4'h0;
    idle(2);
    Reset = 1'b0;
    idle(1);

    // 1: reset values, then full entry and commit
    chk("rst_dout",  dout_a, 32'h0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_idfld", 32'(id_a), 32'd1);
    chk("rst_flags", 32'({derr_a, to_a}), 32'd0);

    digits = 32'h12345678;
    for (int i = 7; i >= 0; i--) begin
      submit(digits[i*4 +: 4]);
      if (i == 4) chk("idfld_cnt4", 32'(id_a), 32'd0);
    end
    chk("full_count", 32'(cnt_a), 32'd8);
    chk("full_valid", 32'(valid_a), 32'd0);
    submit(4'h3);
    chk("commit_valid", 32'(valid_a), 32'd1);
    chk("commit_dout",  dout_a, 32'h12345678);

    // 2: PRESENT holds against strobes until Ready
    idle(5);
    submit(4'h3);
    clear();
    backspace();
    chk("hold_valid", 32'(valid_a), 32'd1);
    chk("hold_dout",  dout_a, 32'h12345678);
    chk("hold_count", 32'(cnt_a), 32'd8);
    ready_pulse();
    chk("xfer_valid", 32'(valid_a), 32'd0);
    chk("xfer_count", 32'(cnt_a), 32'd0);
    chk("xfer_dout",  dout_a, 32'h12345678);

    // 3: backspace mid-entry and at empty
    backspace();
    chk("bs_empty_count", 32'(cnt_a), 32'd0);
    submit(4'd1); submit(4'd2); submit(4'd3);
    chk("three_count", 32'(cnt_a), 32'd3);
    backspace();
    chk("bs_count", 32'(cnt_a), 32'd2);
    digits = 32'h945678;
    for (int i = 5; i >= 0; i--) submit(digits[i*4 +: 4]);
    submit(4'h0);
    chk("bs_dout",  dout_a, 32'h12945678);
    chk("bs_valid", 32'(valid_a), 32'd1);
    ready_pulse();
    chk("bs_xfer_valid", 32'(valid_a), 32'd0);

    // 4: BCD range check, enforced only when BCD_ONLY=1
    submit(4'd1); submit(4'd2);
    submit(4'hA);
    chk("bcd_err_a",   32'(derr_a), 32'd1);
    chk("bcd_count_a", 32'(cnt_a), 32'd2);
    chk("bcd_err_b",   32'(derr_b), 32'd0);
    chk("bcd_count_b", 32'(cnt_b), 32'd3);
    idle(1);
    chk("bcd_pulse_end", 32'(derr_a), 32'd0);
    clear();
    chk("clear_count_b", 32'(cnt_b), 32'd0);

    // 5: inactivity timeout on u_dut_c
    submit(4'd1); submit(4'd2); submit(4'd3);
    idle(9);
    chk("to_early_pulse", 32'(to_c), 32'd0);
    chk("to_early_count", 32'(cnt_c), 32'd3);
    idle(1);
    chk("to_pulse",     32'(to_c), 32'd1);
    chk("to_count",     32'(cnt_c), 32'd0);
    chk("to_noerr",     32'(derr_c), 32'd0);
    chk("to_dflt_keep", 32'(cnt_a), 32'd3);
    idle(1);
    chk("to_pulse_end", 32'(to_c), 32'd0);
    clear();
    submit(4'd1); submit(4'd2); submit(4'd3);
    idle(9);
    submit(4'd4);
    chk("to_restart_pulse", 32'(to_c), 32'd0);
    chk("to_restart_count", 32'(cnt_c), 32'd4);
    idle(9);
    chk("to_restart_wait", 32'(to_c), 32'd0);
    idle(1);
    chk("to_second_pulse", 32'(to_c), 32'd1);
    clear();

    // 6: asynchronous reset mid-entry and during PRESENT
    submit(4'd5); submit(4'd6);
    #2 Reset = 1'b1;
    #1;
    chk("arst_entry_count", 32'(cnt_a), 32'd0);
    chk("arst_entry_idfld", 32'(id_a), 32'd1);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) submit(4'd9);
    submit(4'd0);
    chk("pre_arst_dout", dout_a, 32'h99999999);
    #2 Reset = 1'b1;
    #1;
    chk("arst_pres_valid", 32'(valid_a), 32'd0);
    chk("arst_pres_dout",  dout_a, 32'h0);
    chk("arst_pres_count", 32'(cnt_a), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
